ir_scan_sequencer: RTL and testbench

Schedules the shared A2D converter across the three IR sensor pairs (inner, mid, outer) of the line follower. While motion is enabled it repeatedly runs a scan. Each scan powers one IR pair, waits for the emitter to settle, then converts the left and right channels. After all three pairs it produces a weighted signed line-position error for the motion controller. It sits between the command/motion logic (`go`) and the A2D interface (`strt_cnv`/`chnnl`/`cnv_cmplt`/`A2D_res`). It is the only block allowed to drive the A2D request lines.

---
 rtl/ir_scan_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_ir_scan_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_scan_sequencer.sv
// ir_scan_sequencer
//
// Time-shares the A2D converter across the three IR sensor pairs (inner, mid,
// outer). While go is high it repeats a scan: each pair is powered, allowed to
// settle, then its left and right channels are converted. The weighted sum of
// (left - right) over the three pairs is published as a signed error.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   go         scan enable from motion/command logic
//   strt_cnv   one-cycle conversion request to the A2D
//   chnnl      A2D channel select, stable from strt_cnv until cnv_cmplt
//   cnv_cmplt  one-cycle conversion-done strobe from the A2D
//   A2D_res    unsigned 12-bit result, valid with cnv_cmplt
//   IR_in_en   inner pair emitter enable
//   IR_mid_en  mid pair emitter enable
//   IR_out_en  outer pair emitter enable
//   err        signed scan result, held between scans
//   err_vld    one-cycle strobe when err updates
//   busy       high whenever the sequencer is not idle
//
// All outputs are registered.

module ir_scan_sequencer #(
  parameter int unsigned SETTLE_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic               strt_cnv,
  output logic [2:0]         chnnl,
  input  logic               cnv_cmplt,
  input  logic [11:0]        A2D_res,
  output logic               IR_in_en,
  output logic               IR_mid_en,
  output logic               IR_out_en,
  output logic signed [15:0] err,
  output logic               err_vld,
  output logic               busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSettle = 3'd1;
  localparam logic [2:0] StWaitL  = 3'd2;
  localparam logic [2:0] StWaitR  = 3'd3;
  localparam logic [2:0] StDrain  = 3'd4;

  localparam logic [1:0] PairIn  = 2'd0;
  localparam logic [1:0] PairMid = 2'd1;
  localparam logic [1:0] PairOut = 2'd2;

  localparam logic [15:0] SettleLoad = 16'(SETTLE_CYC - 1);

  logic [2:0]         state_q, state_d;
  logic [1:0]         pair_q, pair_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [11:0]        lft_q, lft_d;
  logic signed [15:0] acc_q, acc_d;
  logic signed [15:0] err_q, err_d;
  logic               err_vld_q, err_vld_d;
  logic               strt_q, strt_d;
  logic [2:0]         chnnl_q, chnnl_d;
  logic [2:0]         en_q, en_d;
  logic               busy_q;

  // Channel map for the pair currently being scanned.
  logic [2:0] chnnl_lft, chnnl_rgt;
  always_comb begin
    chnnl_lft = 3'd1;
    chnnl_rgt = 3'd0;
    case (pair_q)
      PairMid: begin
        chnnl_lft = 3'd4;
        chnnl_rgt = 3'd2;
      end
      PairOut: begin
        chnnl_lft = 3'd3;
        chnnl_rgt = 3'd7;
      end
      default: begin
        chnnl_lft = 3'd1;
        chnnl_rgt = 3'd0;
      end
    endcase
  end

  // Weighted left-right difference; weights 1/2/4 are plain shifts.
  logic signed [12:0] diff;
  logic signed [15:0] diff_ext;
  logic signed [15:0] weighted;
  logic signed [15:0] sum;

  assign diff     = $signed({1'b0, lft_q}) - $signed({1'b0, A2D_res});
  assign diff_ext = $signed({{3{diff[12]}}, diff});

  always_comb begin
    weighted = diff_ext;
    case (pair_q)
      PairMid: weighted = diff_ext <<< 1;
      PairOut: weighted = diff_ext <<< 2;
      default: weighted = diff_ext;
    endcase
  end

  assign sum = acc_q + weighted;

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    cnt_d     = cnt_q;
    lft_d     = lft_q;
    acc_d     = acc_q;
    err_d     = err_q;
    err_vld_d = 1'b0;
    strt_d    = 1'b0;
    chnnl_d   = chnnl_q;
    en_d      = en_q;

    case (state_q)
      StIdle: begin
        chnnl_d = 3'd0;
        en_d    = 3'b000;
        if (go) begin
          pair_d  = PairIn;
          acc_d   = '0;
          en_d    = 3'b001;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
      end

      StSettle: begin
        if (!go) begin
          en_d    = 3'b000;
          chnnl_d = 3'd0;
          state_d = StIdle;
        end else if (cnt_q == 16'd0) begin
          strt_d  = 1'b1;
          chnnl_d = chnnl_lft;
          state_d = StWaitL;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      StWaitL: begin
        if (!go) begin
          en_d = 3'b000;
          // A completion in the abort cycle already retires the conversion.
          if (cnv_cmplt) begin
            chnnl_d = 3'd0;
            state_d = StIdle;
          end else begin
            state_d = StDrain;
          end
        end else if (cnv_cmplt) begin
          lft_d   = A2D_res;
          strt_d  = 1'b1;
          chnnl_d = chnnl_rgt;
          state_d = StWaitR;
        end
      end

      StWaitR: begin
        if (!go) begin
          en_d = 3'b000;
          if (cnv_cmplt) begin
            chnnl_d = 3'd0;
            state_d = StIdle;
          end else begin
            state_d = StDrain;
          end
        end else if (cnv_cmplt) begin
          acc_d = sum;
          if (pair_q != PairOut) begin
            pair_d  = pair_q + 2'd1;
            // Old enable falls and next one rises on the same edge.
            en_d    = (pair_q == PairIn) ? 3'b010 : 3'b100;
            cnt_d   = SettleLoad;
            state_d = StSettle;
          end else begin
            en_d      = 3'b000;
            err_d     = sum;
            err_vld_d = 1'b1;
            chnnl_d   = 3'd0;
            state_d   = StIdle;
          end
        end
      end

      StDrain: begin
        en_d = 3'b000;
        if (cnv_cmplt) begin
          chnnl_d = 3'd0;
          state_d = StIdle;
        end
      end

      default: begin
        en_d    = 3'b000;
        chnnl_d = 3'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pair_q    <= PairIn;
      cnt_q     <= '0;
      lft_q     <= '0;
      acc_q     <= '0;
      err_q     <= '0;
      err_vld_q <= 1'b0;
      strt_q    <= 1'b0;
      chnnl_q   <= 3'd0;
      en_q      <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      cnt_q     <= cnt_d;
      lft_q     <= lft_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
      strt_q    <= strt_d;
      chnnl_q   <= chnnl_d;
      en_q      <= en_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign strt_cnv  = strt_q;
  assign chnnl     = chnnl_q;
  assign IR_in_en  = en_q[0];
  assign IR_mid_en = en_q[1];
  assign IR_out_en = en_q[2];
  assign err       = err_q;
  assign err_vld   = err_vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ir_scan_sequencer.sv
module tb_ir_scan_sequencer;

  localparam int S = 8;
  localparam int N = 4;

  logic               clk;
  logic               rst;
  logic               go;
  logic               strt_cnv;
  logic [2:0]         chnnl;
  logic               cnv_cmplt;
  logic [11:0]        A2D_res;
  logic               IR_in_en;
  logic               IR_mid_en;
  logic               IR_out_en;
  logic signed [15:0] err;
  logic               err_vld;
  logic               busy;

  ir_scan_sequencer #(.SETTLE_CYC(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .A2D_res   (A2D_res),
    .IR_in_en  (IR_in_en),
    .IR_mid_en (IR_mid_en),
    .IR_out_en (IR_out_en),
    .err       (err),
    .err_vld   (err_vld),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [11:0] tab [8];
  int          chq [$];
  int          hold_bad = 0;
  int          en_hi [3];
  int          overlap = 0;
  int          vld_cnt = 0;
  int          cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A2D model: completion is sampled N edges after the edge that raised strt_cnv.
  initial begin
    int ch;
    cnv_cmplt = 1'b0;
    A2D_res   = '0;
    forever begin
      @(posedge clk);
      #1;
      while (strt_cnv && !rst) begin
        ch = int'(chnnl);
        chq.push_back(ch);
        repeat (N - 1) @(posedge clk);
        #1;
        if (int'(chnnl) != ch) hold_bad++;
        cnv_cmplt = 1'b1;
        A2D_res   = tab[ch];
        @(posedge clk);
        #1;
        cnv_cmplt = 1'b0;
        A2D_res   = '0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (IR_in_en)  en_hi[0]++;
    if (IR_mid_en) en_hi[1]++;
    if (IR_out_en) en_hi[2]++;
    if ($countones({IR_in_en, IR_mid_en, IR_out_en}) > 1) overlap++;
    if (err_vld) vld_cnt++;
  end

  task automatic set_tab(input int l1, input int r0, input int l4, input int r2,
                         input int l3, input int r7);
    for (int i = 0; i < 8; i++) tab[i] = '0;
    tab[1] = 12'(l1);
    tab[0] = 12'(r0);
    tab[4] = 12'(l4);
    tab[2] = 12'(r2);
    tab[3] = 12'(l3);
    tab[7] = 12'(r7);
  endtask

  task automatic wait_vld(input string tag, output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err_vld) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    check({tag, "_vld_seen"}, int'(ok), 1);
  endtask

  task automatic check_idle_outputs(input string tag, input int exp_err);
    check({tag, "_strt"}, int'(strt_cnv), 0);
    check({tag, "_chnnl"}, int'(chnnl), 0);
    check({tag, "_en"}, int'({IR_in_en, IR_mid_en, IR_out_en}), 0);
    check({tag, "_err"}, int'(err), exp_err);
    check({tag, "_vld"}, int'(err_vld), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic run_scan(input string tag, input int exp_err, input bit full);
    int t;
    chq.delete();
    for (int i = 0; i < 3; i++) en_hi[i] = 0;
    overlap = 0;
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    wait_vld(tag, t);
    go = 1'b0;
    check({tag, "_err"}, int'(err), exp_err);
    if (full) begin
      check({tag, "_lat"}, t, 3 * (S + 2 * N));
      check({tag, "_nconv"}, chq.size(), 6);
      if (chq.size() == 6) begin
        check({tag, "_ch0"}, chq[0], 1);
        check({tag, "_ch1"}, chq[1], 0);
        check({tag, "_ch2"}, chq[2], 4);
        check({tag, "_ch3"}, chq[3], 2);
        check({tag, "_ch4"}, chq[4], 3);
        check({tag, "_ch5"}, chq[5], 7);
      end
      check({tag, "_in_cyc"}, en_hi[0], S + 2 * N);
      check({tag, "_mid_cyc"}, en_hi[1], S + 2 * N);
      check({tag, "_out_cyc"}, en_hi[2], S + 2 * N);
      check({tag, "_overlap"}, overlap, 0);
    end
  endtask

  initial begin
    int t;
    int c0, c1;
    int vb;

    rst = 1'b1;
    go  = 1'b0;
    for (int i = 0; i < 8; i++) tab[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_held", 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst_rel", 0);

    // Nominal: 200*1 + 0*2 + (-100)*4 = -200
    set_tab(1000, 800, 500, 500, 0, 100);
    run_scan("nom", -200, 1'b1);

    set_tab(4095, 0, 4095, 0, 4095, 0);
    run_scan("max", 28665, 1'b1);
    set_tab(0, 4095, 0, 4095, 0, 4095);
    run_scan("min", -28665, 1'b1);

    // Continuous go: three scans, 49 cycles apart.
    repeat (2) @(negedge clk);
    set_tab(1000, 800, 500, 500, 0, 100);
    @(negedge clk);
    go = 1'b1;
    wait_vld("cont1", t);
    c0 = cyc;
    check("cont1_err", int'(err), -200);
    // 1000*1 + (-200)*2 + 10*4 = 640
    set_tab(2000, 1000, 100, 300, 50, 40);
    wait_vld("cont2", t);
    c1 = cyc;
    check("cont2_err", int'(err), 640);
    check("cont2_gap", c1 - c0, 49);
    set_tab(4095, 0, 4095, 0, 4095, 0);
    wait_vld("cont3", t);
    check("cont3_err", int'(err), 28665);
    check("cont3_gap", cyc - c1, 49);
    go = 1'b0;
    repeat (2) @(negedge clk);
    check("cont_idle", int'(busy), 0);

    // Abort while waiting on the left conversion.
    set_tab(1000, 800, 500, 500, 0, 100);
    vb = vld_cnt;
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    repeat (8) @(negedge clk);
    @(negedge clk);
    check("abort_strt", int'(strt_cnv), 1);
    check("abort_chnnl", int'(chnnl), 1);
    @(negedge clk);
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("abort_en_low", int'({IR_in_en, IR_mid_en, IR_out_en}), 0);
    check("abort_drain_busy", int'(busy), 1);
    check("abort_drain_strt", int'(strt_cnv), 0);
    go = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    check("abort_idle_strt", int'(strt_cnv), 0);
    @(negedge clk);
    check("abort_restart_busy", int'(busy), 1);
    check("abort_restart_in", int'(IR_in_en), 1);
    check("abort_restart_strt", int'(strt_cnv), 0);
    go = 1'b0;
    @(negedge clk);
    check("abort_settle_quit", int'(busy), 0);
    check("abort_err_kept", int'(err), 28665);
    check("abort_no_vld", vld_cnt - vb, 0);

    // Reset during mid-pair settle.
    repeat (2) @(negedge clk);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    repeat (20) @(negedge clk);
    check("rstmid_mid_en", int'(IR_mid_en), 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rstmid_async", 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_restart_in", int'(IR_in_en), 1);
    check("rstmid_restart_mid", int'(IR_mid_en), 0);
    wait_vld("rstmid", t);
    check("rstmid_err", int'(err), -200);
    go = 1'b0;
    repeat (2) @(negedge clk);

    // Stray completion strobe during settle.
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    A2D_res   = 12'hABC;
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    A2D_res   = '0;
    wait_vld("stray", t);
    check("stray_err", int'(err), -200);
    go = 1'b0;
    repeat (3) @(negedge clk);

    check("chnnl_hold", hold_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
